// File: rtl/alu_wb_stage_pkg.sv
// rtl/alu_wb_stage_pkg.sv - shared types and sizes for the ALU writeback buffer
package alu_wb_stage_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DEPTH  = 2;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
    logic                 we;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_wb_fifo2.sv
// rtl/alu_wb_stage_wb_fifo2.sv - two-slot in-order entry buffer with per-slot visibility
module wb_fifo2
  import alu_wb_stage_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output wb_entry_t                  head,
  output logic [WB_DEPTH-1:0]        slot_valid,
  output wb_entry_t [WB_DEPTH-1:0]   slot_entry
);

  wb_entry_t [WB_DEPTH-1:0] slots;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;
  logic                     push_ok;
  logic                     pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slots  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 2'd1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 2'd1;
      end
    end
  end

  // Stale slot contents stay hidden: head reads zero when nothing is buffered.
  assign head       = empty ? '0 : slots[rd_ptr];
  assign slot_entry = slots;

  always_comb begin
    slot_valid = '0;
    if (count == 2'd2) begin
      slot_valid = '1;
    end else if (count == 2'd1) begin
      slot_valid[rd_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU result writeback buffer with flag registers and hazard scoreboard
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int W  = WB_DATA_W,
  parameter int AW = WB_ADDR_W,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_sc,
  input  logic          alu_zero,
  input  logic          alu_pf,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_we,
  input  logic          flag_we,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_addr,
  output logic [W-1:0]  wb_data,
  output logic          wb_we,
  output logic          cf,
  output logic          zf,
  output logic          pf,
  input  logic [AW-1:0] hz_addr,
  output logic          hz_hit,
  output logic [CW-1:0] retired
);

  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  wb_entry_t                push_entry;
  wb_entry_t                head;
  logic [WB_DEPTH-1:0]      slot_valid;
  wb_entry_t [WB_DEPTH-1:0] slot_entry;

  assign in_ready = ~full;
  assign wb_valid = ~empty;
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  assign push_entry.data = alu_out;
  assign push_entry.addr = rd_addr;
  assign push_entry.we   = rd_we;

  wb_fifo2 u_fifo (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .slot_valid (slot_valid),
    .slot_entry (slot_entry)
  );

  assign wb_addr = head.addr;
  assign wb_data = head.data;
  assign wb_we   = head.we;

  // Flags follow the push so the very next ALU op sees the new carry, regardless of writeback stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cf <= 1'b0;
      zf <= 1'b0;
      pf <= 1'b0;
    end else if (push && flag_we) begin
      cf <= alu_sc;
      zf <= alu_zero;
      pf <= alu_pf;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retired <= '0;
    end else if (pop) begin
      retired <= retired + CW'(1);
    end
  end

  always_comb begin
    hz_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (slot_valid[i] && slot_entry[i].we && (slot_entry[i].addr == hz_addr)) begin
        hz_hit = 1'b1;
      end
    end
  end

endmodule
